// File: rtl/gt_pattern_player.sv
// gt_pattern_player: multi-lane pattern RAM playback engine (optional PRBS31 source under GT_PAT_PRBS_EN)
module gt_pattern_player #(
  parameter int CHN_NUM = 6,
  parameter int DATA_W  = 32,
  parameter int RAM_AW  = 10,
  parameter int LOOP_W  = 16
) (
  input  logic                       gt_clk,
  input  logic                       gt_rst,
  input  logic                       ram_we,
  input  logic [$clog2(CHN_NUM)-1:0] ram_idx,
  input  logic [RAM_AW-1:0]          ram_addr,
  input  logic [DATA_W-1:0]          ram_data,
  input  logic [RAM_AW-1:0]          cfg_last,
  input  logic [LOOP_W-1:0]          cfg_loops,
`ifdef GT_PAT_PRBS_EN
  input  logic                       cfg_prbs,
`endif
  input  logic                       reg_start,
  input  logic                       reg_stop,
  output logic [CHN_NUM*DATA_W-1:0]  gt_data,
  output logic                       gt_valid,
  output logic                       busy,
  output logic                       done,
  output logic [LOOP_W-1:0]          pass_cnt
);
  typedef enum logic [1:0] {IDLE, FILL, PLAY, DRAIN} state_t;
  state_t state, state_n;
  logic start_r, start_p, stop_r, stop_p, start_e, stop_e;
  logic stop_f, drain_q, v1, w1, reading, wrap, finish, load;
  logic [RAM_AW-1:0] last_q, rd_addr;
  logic [LOOP_W-1:0] loops_q, rd_pass;
  logic [CHN_NUM*DATA_W-1:0] rdata;
`ifdef GT_PAT_PRBS_EN
  logic prbs_q;
`endif
  assign start_e = start_r & ~start_p;
  assign stop_e  = stop_r & ~stop_p;
  assign busy    = state != IDLE;
  assign load    = state == IDLE && start_e;
  // read-side control: pass boundary detection and next state
  always_comb begin
    reading = state == FILL || state == PLAY;
    wrap    = reading && rd_addr == last_q;
    finish  = wrap && (stop_f || stop_e || (loops_q != '0 && rd_pass + LOOP_W'(1) == loops_q));
    state_n = state;
    case (state)
      IDLE:       state_n = start_e ? FILL : IDLE;
      FILL, PLAY: state_n = finish ? DRAIN : PLAY;
      DRAIN:      state_n = drain_q ? IDLE : DRAIN;
      default:    state_n = IDLE;
    endcase
  end
  // state, edge detectors, read pointer and two-stage output pipeline
  always_ff @(posedge gt_clk) begin
    if (gt_rst) begin
      state    <= IDLE;
      start_r  <= 1'b0;
      start_p  <= 1'b0;
      stop_r   <= 1'b0;
      stop_p   <= 1'b0;
      stop_f   <= 1'b0;
      drain_q  <= 1'b0;
      v1       <= 1'b0;
      w1       <= 1'b0;
      last_q   <= '0;
      loops_q  <= '0;
      rd_addr  <= '0;
      rd_pass  <= '0;
      gt_data  <= '0;
      gt_valid <= 1'b0;
      done     <= 1'b0;
      pass_cnt <= '0;
`ifdef GT_PAT_PRBS_EN
      prbs_q   <= 1'b0;
`endif
    end else begin
      state   <= state_n;
      start_r <= reg_start;
      start_p <= start_r;
      stop_r  <= reg_stop;
      stop_p  <= stop_r;
      if (load) begin
        last_q   <= cfg_last;
        loops_q  <= cfg_loops;
        pass_cnt <= '0;
        stop_f   <= 1'b0;
        rd_addr  <= '0;
        rd_pass  <= '0;
`ifdef GT_PAT_PRBS_EN
        prbs_q   <= cfg_prbs;
`endif
      end else begin
        if (reading) rd_addr <= wrap ? '0 : rd_addr + RAM_AW'(1);
        rd_pass  <= rd_pass + LOOP_W'(wrap);
        stop_f   <= stop_f | (stop_e && busy);
        pass_cnt <= pass_cnt + LOOP_W'(w1 && ~&pass_cnt);
      end
      drain_q  <= state == DRAIN && !drain_q;
      done     <= state == DRAIN && drain_q;
      v1       <= reading;
      w1       <= wrap;
      gt_valid <= v1;
      gt_data  <= v1 ? rdata : '0;
    end
  end
  for (genvar i = 0; i < CHN_NUM; i++) begin : g_lane
    logic [DATA_W-1:0] mem [2**RAM_AW];
    logic [DATA_W-1:0] q;
    assign rdata[i*DATA_W +: DATA_W] = q;
`ifdef GT_PAT_PRBS_EN
    logic [30:0] lfsr, lfsr_n;
    logic [DATA_W-1:0] pw;
    // PRBS31 (x^31+x^28+1): DATA_W serial steps per cycle, first bit generated lands in the MSB
    always_comb begin
      lfsr_n = lfsr;
      pw = '0;
      for (int b = DATA_W - 1; b >= 0; b--) begin
        pw[b] = lfsr_n[30] ^ lfsr_n[27];
        lfsr_n = {lfsr_n[29:0], pw[b]};
      end
    end
    // generator reseeds on every start and advances once per word read
    always_ff @(posedge gt_clk) begin
      if (gt_rst || load) lfsr <= 31'(i + 1);
      else if (reading && prbs_q) lfsr <= lfsr_n;
    end
    // pattern RAM: write port, read-first sync read port, PRBS substitutes for RAM data
    always_ff @(posedge gt_clk) begin
      if (ram_we && 32'(ram_idx) == i) mem[ram_addr] <= ram_data;
      q <= prbs_q ? pw : mem[rd_addr];
    end
`else
    // pattern RAM: write port, read-first sync read port
    always_ff @(posedge gt_clk) begin
      if (ram_we && 32'(ram_idx) == i) mem[ram_addr] <= ram_data;
      q <= mem[rd_addr];
    end
`endif
  end
endmodule

// File: tb/tb_gt_pattern_player.sv
// tb_gt_pattern_player: randomized self-checking bench for gt_pattern_player against a RAM/sequence model
module tb_gt_pattern_player;
  localparam int CN = 6, DW = 32, AW = 10, LW = 16;
  logic clk = 1'b0, rst = 1'b1, ram_we = 1'b0, reg_start = 1'b0, reg_stop = 1'b0;
  logic [2:0] ram_idx = '0;
  logic [AW-1:0] ram_addr = '0, cfg_last = '0;
  logic [DW-1:0] ram_data = '0;
  logic [LW-1:0] cfg_loops = '0, pass_cnt;
  logic [CN*DW-1:0] gt_data;
  logic gt_valid, busy, done;
`ifdef GT_PAT_PRBS_EN
  logic cfg_prbs = 1'b0;
`endif
  int total = 0, bad = 0;
  logic [DW-1:0] tb_mem [CN][2**AW];
  logic [CN*DW-1:0] got [$];
  int n_done, first_at, gaps, idle_nonzero;

  gt_pattern_player dut (
    .gt_clk(clk), .gt_rst(rst), .ram_we(ram_we), .ram_idx(ram_idx), .ram_addr(ram_addr),
    .ram_data(ram_data), .cfg_last(cfg_last), .cfg_loops(cfg_loops),
`ifdef GT_PAT_PRBS_EN
    .cfg_prbs(cfg_prbs),
`endif
    .reg_start(reg_start), .reg_stop(reg_stop), .gt_data(gt_data), .gt_valid(gt_valid),
    .busy(busy), .done(done), .pass_cnt(pass_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [CN*DW-1:0] exp_word(input int a);
    logic [CN*DW-1:0] w;
    for (int k = 0; k < CN; k++) w[k*DW +: DW] = tb_mem[k][a];
    return w;
  endfunction

  task automatic write_word(input int k, input int a, input logic [DW-1:0] d);
    ram_we = 1'b1;
    ram_idx = 3'(k);
    ram_addr = AW'(a);
    ram_data = d;
    if (k < CN) tb_mem[k][a] = d;
    @(negedge clk);
    ram_we = 1'b0;
  endtask

  task automatic capture(input int stop_at, input int budget, input bit inject);
    bit ended = 0;
    int after = 0;
    got.delete();
    n_done = 0; first_at = -1; gaps = 0; idle_nonzero = 0;
    reg_start = 1'b1;
    for (int n = 1; n <= budget && after < 4; n++) begin
      @(negedge clk);
      if (n == 2) reg_start = 1'b0;
      if (inject && n == 5) reg_start = 1'b1;
      if (inject && n == 7) reg_start = 1'b0;
      if (inject && n >= 4 && n < 8) begin
        ram_we = 1'b1; ram_idx = 3'(6 + n % 2); ram_addr = AW'(n - 4); ram_data = $urandom;
      end else ram_we = 1'b0;
      if (gt_valid) begin
        got.push_back(gt_data);
        if (first_at < 0) first_at = n;
        if (ended) gaps++;
      end else if (first_at >= 0) ended = 1;
      if (!gt_valid && gt_data !== '0) idle_nonzero++;
      if (done) n_done++;
      if (stop_at > 0 && got.size() == stop_at) reg_stop = 1'b1;
      if (n_done > 0) after++;
    end
    reg_stop = 1'b0;
    ram_we = 1'b0;
  endtask

  task automatic test_reset;
    repeat (3) @(negedge clk);
    total += 4;
    if (gt_valid !== 1'b0) begin bad++; $display("FAIL rst_valid got=%b exp=0", gt_valid); end
    if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy got=%b exp=0", busy); end
    if (done !== 1'b0) begin bad++; $display("FAIL rst_done got=%b exp=0", done); end
    if (pass_cnt !== '0) begin bad++; $display("FAIL rst_pass got=%0d exp=0", pass_cnt); end
    rst = 1'b0;
    @(negedge clk);
    total++;
    if (gt_data !== '0) begin bad++; $display("FAIL rst_data got=%h exp=0", gt_data); end
  endtask

  task automatic test_basic;
    for (int k = 0; k < CN; k++) for (int a = 0; a < 4; a++) write_word(k, a, {8'(k), 24'(a)});
    cfg_last = 3; cfg_loops = 2;
    @(negedge clk);
    capture(0, 60, 0);
    total += 7;
    if (got.size() != 8) begin bad++; $display("FAIL basic_len got=%0d exp=8", got.size()); end
    if (first_at != 4) begin bad++; $display("FAIL basic_latency got=%0d exp=4", first_at); end
    if (n_done != 1) begin bad++; $display("FAIL basic_done got=%0d exp=1", n_done); end
    if (pass_cnt !== 2) begin bad++; $display("FAIL basic_pass got=%0d exp=2", pass_cnt); end
    if (gaps != 0) begin bad++; $display("FAIL basic_gap got=%0d exp=0", gaps); end
    if (idle_nonzero != 0) begin bad++; $display("FAIL basic_idle_data got=%0d exp=0", idle_nonzero); end
    if (busy !== 1'b0) begin bad++; $display("FAIL basic_busy got=%b exp=0", busy); end
    for (int i = 0; i < got.size(); i++) begin
      total++;
      if (got[i] !== exp_word(i % 4)) begin bad++; $display("FAIL basic_word%0d got=%h exp=%h", i, got[i], exp_word(i % 4)); end
    end
  endtask

  task automatic test_random;
    for (int it = 0; it < 4; it++) begin
      int last, loops;
      for (int k = 0; k < CN; k++) for (int a = 0; a < 16; a++) write_word(k, a, $urandom);
      last = $urandom_range(0, 15);
      loops = $urandom_range(1, 3);
      cfg_last = AW'(last); cfg_loops = LW'(loops);
      @(negedge clk);
      capture(0, loops * (last + 1) + 30, 0);
      total += 5;
      if (got.size() != loops * (last + 1)) begin bad++; $display("FAIL rand%0d_len got=%0d exp=%0d", it, got.size(), loops * (last + 1)); end
      if (first_at != 4) begin bad++; $display("FAIL rand%0d_latency got=%0d exp=4", it, first_at); end
      if (n_done != 1) begin bad++; $display("FAIL rand%0d_done got=%0d exp=1", it, n_done); end
      if (pass_cnt !== LW'(loops)) begin bad++; $display("FAIL rand%0d_pass got=%0d exp=%0d", it, pass_cnt, loops); end
      if (gaps != 0) begin bad++; $display("FAIL rand%0d_gap got=%0d exp=0", it, gaps); end
      for (int i = 0; i < got.size(); i++) begin
        total++;
        if (got[i] !== exp_word(i % (last + 1))) begin bad++; $display("FAIL rand%0d_word%0d got=%h exp=%h", it, i, got[i], exp_word(i % (last + 1))); end
      end
    end
  endtask

  task automatic test_stop;
    cfg_last = 7; cfg_loops = 0;
    @(negedge clk);
    capture(20, 120, 0);
    total += 3;
    if (got.size() != 24) begin bad++; $display("FAIL stop_len got=%0d exp=24", got.size()); end
    if (n_done != 1) begin bad++; $display("FAIL stop_done got=%0d exp=1", n_done); end
    if (pass_cnt !== 3) begin bad++; $display("FAIL stop_pass got=%0d exp=3", pass_cnt); end
    for (int i = 0; i < got.size(); i++) begin
      total++;
      if (got[i] !== exp_word(i % 8)) begin bad++; $display("FAIL stop_word%0d got=%h exp=%h", i, got[i], exp_word(i % 8)); end
    end
  endtask

  task automatic test_single;
    cfg_last = 0; cfg_loops = 5;
    @(negedge clk);
    capture(0, 40, 0);
    total += 4;
    if (got.size() != 5) begin bad++; $display("FAIL single_len got=%0d exp=5", got.size()); end
    if (gaps != 0) begin bad++; $display("FAIL single_gap got=%0d exp=0", gaps); end
    if (n_done != 1) begin bad++; $display("FAIL single_done got=%0d exp=1", n_done); end
    if (pass_cnt !== 5) begin bad++; $display("FAIL single_pass got=%0d exp=5", pass_cnt); end
    for (int i = 0; i < got.size(); i++) begin
      total++;
      if (got[i] !== exp_word(0)) begin bad++; $display("FAIL single_word%0d got=%h exp=%h", i, got[i], exp_word(0)); end
    end
  endtask

  task automatic test_busy_ignored;
    cfg_last = 3; cfg_loops = 3;
    @(negedge clk);
    capture(0, 80, 1);
    total += 3;
    if (got.size() != 12) begin bad++; $display("FAIL busy_len got=%0d exp=12", got.size()); end
    if (n_done != 1) begin bad++; $display("FAIL busy_done got=%0d exp=1", n_done); end
    if (pass_cnt !== 3) begin bad++; $display("FAIL busy_pass got=%0d exp=3", pass_cnt); end
    for (int i = 0; i < got.size(); i++) begin
      total++;
      if (got[i] !== exp_word(i % 4)) begin bad++; $display("FAIL busy_word%0d got=%h exp=%h", i, got[i], exp_word(i % 4)); end
    end
    cfg_last = 15; cfg_loops = 1;
    @(negedge clk);
    capture(0, 60, 0);
    total++;
    if (got.size() != 16) begin bad++; $display("FAIL ram_intact_len got=%0d exp=16", got.size()); end
    for (int i = 0; i < got.size(); i++) begin
      total++;
      if (got[i] !== exp_word(i)) begin bad++; $display("FAIL ram_intact%0d got=%h exp=%h", i, got[i], exp_word(i)); end
    end
  endtask

  task automatic test_reset_mid;
    int dn = 0;
    cfg_last = 7; cfg_loops = 0;
    reg_start = 1'b1;
    for (int n = 1; n <= 8; n++) begin
      @(negedge clk);
      if (n == 2) reg_start = 1'b0;
    end
    total++;
    if (gt_valid !== 1'b1) begin bad++; $display("FAIL mid_valid_before got=%b exp=1", gt_valid); end
    rst = 1'b1;
    @(negedge clk);
    total += 4;
    if (gt_valid !== 1'b0) begin bad++; $display("FAIL mid_valid got=%b exp=0", gt_valid); end
    if (busy !== 1'b0) begin bad++; $display("FAIL mid_busy got=%b exp=0", busy); end
    if (gt_data !== '0) begin bad++; $display("FAIL mid_data got=%h exp=0", gt_data); end
    if (done !== 1'b0) begin bad++; $display("FAIL mid_done got=%b exp=0", done); end
    rst = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (done) dn++;
    end
    total++;
    if (dn != 0) begin bad++; $display("FAIL mid_done_after got=%0d exp=0", dn); end
    cfg_last = 3; cfg_loops = 2;
    capture(0, 60, 0);
    total += 2;
    if (got.size() != 8) begin bad++; $display("FAIL mid_restart_len got=%0d exp=8", got.size()); end
    if (n_done != 1) begin bad++; $display("FAIL mid_restart_done got=%0d exp=1", n_done); end
    for (int i = 0; i < got.size(); i++) begin
      total++;
      if (got[i] !== exp_word(i % 4)) begin bad++; $display("FAIL mid_restart_word%0d got=%h exp=%h", i, got[i], exp_word(i % 4)); end
    end
  endtask

`ifdef GT_PAT_PRBS_EN
  task automatic test_prbs;
    bit bits [CN][$];
    for (int k = 0; k < CN; k++) begin
      logic [30:0] seed = 31'(k + 1);
      for (int j = 30; j >= 0; j--) bits[k].push_back(seed[j]);
      for (int n = 0; n < DW * 1024; n++) bits[k].push_back(bits[k][bits[k].size() - 31] ^ bits[k][bits[k].size() - 28]);
    end
    cfg_prbs = 1'b1; cfg_last = 1023; cfg_loops = 1;
    @(negedge clk);
    capture(0, 1100, 0);
    cfg_prbs = 1'b0;
    total += 2;
    if (got.size() != 1024) begin bad++; $display("FAIL prbs_len got=%0d exp=1024", got.size()); end
    if (n_done != 1) begin bad++; $display("FAIL prbs_done got=%0d exp=1", n_done); end
    for (int i = 0; i < got.size(); i++) begin
      logic [CN*DW-1:0] e;
      for (int k = 0; k < CN; k++) for (int j = 0; j < DW; j++) e[k*DW + DW - 1 - j] = bits[k][31 + i*DW + j];
      total++;
      if (got[i] !== e) begin bad++; $display("FAIL prbs_word%0d got=%h exp=%h", i, got[i], e); end
    end
  endtask
`endif

  initial begin
    test_reset;
    test_basic;
    test_random;
    test_stop;
    test_single;
    test_busy_ignored;
    test_reset_mid;
`ifdef GT_PAT_PRBS_EN
    test_prbs;
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
